// File: rtl/eth_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_sched_pkg
//
// Purpose: definitions shared by the layer-2 transmit grant scheduler.
//   - sched_state_t : scheduler FSM states (IDLE -> ACTIVE -> GAP -> IDLE)
//   - PORT_ARP / PORT_IPV4 : requester indices (index 0 has highest priority)
//   - PERF_W, perf_port_t : width and container of per-port grant counters
//                           used when ETH_TX_SCHED_PERF_EN is defined
// -----------------------------------------------------------------------------
package eth_tx_sched_pkg;

  // Requester indices. Lower index means higher fixed priority.
  localparam int PORT_ARP  = 0;
  localparam int PORT_IPV4 = 1;

  // Width of every performance counter; counters wrap modulo 2**PERF_W.
  localparam int PERF_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for an eligible request
    ST_ACTIVE = 2'd1,  // grant held until frame_done or watchdog expiry
    ST_GAP    = 2'd2   // enforced inter-frame gap, grant low
  } sched_state_t;

  // Per-port performance record.
  typedef struct packed {
    logic [PERF_W-1:0] grants;  // grants issued to this port
  } perf_port_t;

endpackage : eth_tx_sched_pkg

// File: rtl/eth_tx_sched_pick.sv
// -----------------------------------------------------------------------------
// eth_tx_sched_pick
//
// Purpose: combinational fixed-priority picker. Returns a one-hot vector with
// only the lowest-index set bit of the input (index 0 wins).
//
// Ports:
//   i_vec    in  N  candidate vector
//   o_onehot out N  one-hot winner, all zero when i_vec is zero
//   o_any    out 1  at least one candidate present
// -----------------------------------------------------------------------------
module eth_tx_sched_pick
  import eth_tx_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] i_vec,
  output logic [N-1:0] o_onehot,
  output logic         o_any
);

  // x & -x isolates the lowest set bit, which is the highest-priority port.
  assign o_onehot = i_vec & (~i_vec + N'(1));
  assign o_any    = |i_vec;

endmodule : eth_tx_sched_pick

// File: rtl/eth_tx_scheduler.sv
// -----------------------------------------------------------------------------
// eth_tx_scheduler
//
// Purpose: grant controller for the shared layer-2 transmit path. Requesters
// (ARP, IPv4, ...) raise req while they hold a committed frame. In IDLE the
// scheduler picks a winner (aged ports first, then strict priority by index),
// holds a one-hot grant until frame_done, then enforces an inter-frame gap.
// A watchdog aborts a grant that never sees frame_done.
//
// Parameters:
//   NUM_PORTS    number of requesters (index 0 highest priority)
//   AGE_LIMIT    selections a waiting port may lose before it is promoted
//   IFG_CYCLES   idle cycles between a grant drop and the next grant
//   DONE_TIMEOUT cycles in ACTIVE without frame_done before abort
//
// Ports:
//   clk          in  1          clock
//   rst_n        in  1          asynchronous active-low reset
//   req          in  NUM_PORTS  per-port frame-waiting level
//   link_up      in  1          MAC link status; blocks new grants when low
//   frame_done   in  1          pulse: granted frame committed or dropped
//   grant        out NUM_PORTS  one-hot owner, zero outside ACTIVE
//   grant_valid  out 1          high exactly while in ACTIVE
//   abort        out 1          one-cycle pulse on watchdog expiry
//   perf_grants  out NUM_PORTS*32  per-port grant counts  (ETH_TX_SCHED_PERF_EN)
//   perf_aborts  out 32            watchdog abort count   (ETH_TX_SCHED_PERF_EN)
//
// Build option: define ETH_TX_SCHED_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
module eth_tx_scheduler
  import eth_tx_sched_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int AGE_LIMIT    = 8,
  parameter int IFG_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 link_up,
  input  logic                 frame_done,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_valid,
  output logic                 abort
`ifdef ETH_TX_SCHED_PERF_EN
  ,
  output logic [NUM_PORTS*PERF_W-1:0] perf_grants,
  output logic [PERF_W-1:0]           perf_aborts
`endif
);

  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam int WD_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(AGE_LIMIT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(DONE_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  // With no gap configured a released grant goes straight back to IDLE.
  localparam sched_state_t ST_AFTER = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  sched_state_t         r_state;
  sched_state_t         w_state_next;
  logic [NUM_PORTS-1:0] r_owner;
  logic [WD_W-1:0]      r_wd;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_abort;

  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_aged;
  logic [NUM_PORTS-1:0] w_pick_aged;
  logic [NUM_PORTS-1:0] w_pick_elig;
  logic [NUM_PORTS-1:0] w_winner;
  logic                 w_any_aged;
  logic                 w_any_elig;
  logic                 w_select;
  logic                 w_wd_expire;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_elig = link_up ? req : '0;

  eth_tx_sched_pick #(.N(NUM_PORTS)) u_pick_aged (
    .i_vec    (w_aged),
    .o_onehot (w_pick_aged),
    .o_any    (w_any_aged)
  );

  eth_tx_sched_pick #(.N(NUM_PORTS)) u_pick_elig (
    .i_vec    (w_elig),
    .o_onehot (w_pick_elig),
    .o_any    (w_any_elig)
  );

  // A port that has been passed over AGE_LIMIT times beats any fresh request.
  assign w_winner = w_any_aged ? w_pick_aged : w_pick_elig;

  // Selection cycle: the only cycle in which ages and the owner change.
  assign w_select = (r_state == ST_IDLE) && w_any_elig;

  // frame_done in the expiry cycle takes precedence, so no abort then.
  assign w_wd_expire = (r_state == ST_ACTIVE) && !frame_done && (r_wd == WD_LAST);

  // ---------------------------------------------------------------------------
  // Per-port age counters (and optional grant counters)
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [AGE_W-1:0] r_age;

      // Ages move only on selection cycles; a dropped req keeps its age.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_age <= '0;
        end else if (w_select) begin
          if (w_winner[gi]) begin
            r_age <= '0;
          end else if (req[gi] && (r_age != AGE_MAX)) begin
            r_age <= r_age + AGE_W'(1);
          end
        end
      end

      assign w_aged[gi] = w_elig[gi] && (r_age == AGE_MAX);

`ifdef ETH_TX_SCHED_PERF_EN
      perf_port_t r_perf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_perf <= '0;
        end else if (w_select && w_winner[gi]) begin
          r_perf.grants <= r_perf.grants + PERF_W'(1);
        end
      end

      assign perf_grants[gi*PERF_W +: PERF_W] = r_perf.grants;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_elig) begin
          w_state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // req and link_up are deliberately ignored while a frame is in flight.
        if (frame_done || w_wd_expire) begin
          w_state_next = ST_AFTER;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Deriving grant from the state means an asynchronous reset clears it at
  // once, without waiting for a clock edge.
  always_comb begin
    grant_valid = (r_state == ST_ACTIVE);
    grant       = grant_valid ? r_owner : '0;
    abort       = r_abort;
  end

  // ---------------------------------------------------------------------------
  // Owner, watchdog, gap counter, abort pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
    end else if (w_select) begin
      r_owner <= w_winner;
    end
  end

  // Counts ACTIVE cycles; the state leaves ACTIVE at WD_LAST so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if ((r_state == ST_ACTIVE) && !frame_done && !w_wd_expire) begin
      r_wd <= r_wd + WD_W'(1);
    end else begin
      r_wd <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if ((r_state == ST_GAP) && (r_gap_cnt != GAP_LAST)) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // Registered so the pulse coincides with the grant drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_wd_expire;
    end
  end

`ifdef ETH_TX_SCHED_PERF_EN
  logic [PERF_W-1:0] r_perf_aborts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_aborts <= '0;
    end else if (w_wd_expire) begin
      r_perf_aborts <= r_perf_aborts + PERF_W'(1);
    end
  end

  assign perf_aborts = r_perf_aborts;
`endif

endmodule : eth_tx_scheduler
